phy_tx_lane_scheduler: RTL
==========================

Name: phy_tx_lane_scheduler

Overview:
- Shares one PHY TX serializer byte slot among N_CH requester FIFOs.
- Sequences the link through comma training: COMMA bytes until the link is active.
- Once active, grants the link round-robin in bursts. Each burst is prefixed by a start-of-channel (SOC) symbol, and idle slots are filled with COMMA.
- Sits between the per-lane FWFT FIFOs and the parallel-to-serial PHY TX. The output stream is what the PHY RX comma/activity detector locks onto.

Parameters:
- N_CH, 4, number of requesters; legal range 2..4.
- BURST_LEN, 4, maximum data bytes per grant; legal range 1..15.
- TRAIN_LEN, 4, COMMA bytes sent in TRAIN before going active; legal range 1..15.
- COMMA, 8'hBC, idle/training symbol.
- SOC_BASE, 8'hF0, SOC symbol = SOC_BASE + channel index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  link enable.
- req_valid  in  N_CH  FIFO non-empty, one bit per channel.
- req_data  in  8*N_CH  FIFO head byte; channel k occupies bits [8k+7:8k].
- req_pop  out  N_CH  one-cycle pop strobe to the FIFO.
- ser_ready  in  1  serializer load strobe; one-cycle pulse, spacing at least 2 cycles.
- ser_data  out  8  byte presented to the serializer (registered).
- ser_valid  out  1  ser_data is SOC or payload (not COMMA).
- active  out  1  link trained; high in IDLE and BURST.
- grant_ch  out  2  channel of the current or last burst.
- err_reserved  out  1  sticky: a payload byte equalled COMMA or an SOC code.

Behaviour:
Reset values:
- ser_data=COMMA, ser_valid=0, active=0, grant_ch=0, req_pop=0, err_reserved=0.
- State TRAIN, train_cnt=0, burst_cnt=0, rr_ptr=0.

Slot timing:
- ser_data always holds the next byte. The serializer samples it in the cycle ser_ready=1 (cycle t).
- In cycle t the block decides the following byte and registers it into ser_data/ser_valid at t+1.
- req_pop[k] is combinational, high in cycle t only, when a payload byte of channel k is selected.
- Nothing changes in cycles without ser_ready, apart from enable-driven state changes noted below.

State TRAIN:
- Each slot selects COMMA.
- With enable=1: train_cnt++. When train_cnt reaches TRAIN_LEN, go to IDLE; active=1 from t+1.
- With enable=0: train_cnt is held at 0.

State IDLE, per slot:
- enable=0: select COMMA, go to TRAIN, clear train_cnt, active=0 at t+1.
- Otherwise, if any req_valid is set: pick the first set bit searching from rr_ptr upward with wrap. Select SOC_BASE+k, set grant_ch=k, burst_cnt=0, go to BURST.
- Otherwise: select COMMA.

State BURST (channel g), per slot:
- enable=0: select COMMA, go to TRAIN (burst aborted, no pop).
- If req_valid[g]=1 and burst_cnt<BURST_LEN: select req_data[g], pulse req_pop[g], burst_cnt++.
- Otherwise the burst ends in this same slot: set rr_ptr=(g+1) mod N_CH, then apply the IDLE arbitration rule. This gives a back-to-back SOC or a COMMA, with no wasted slot.

Other rules:
- ser_valid=1 for SOC and payload bytes, 0 for COMMA.
- A payload byte equal to COMMA or in SOC_BASE..SOC_BASE+N_CH-1 is transmitted unchanged and sets err_reserved. err_reserved clears only on reset.
- A channel that empties mid-burst ends the burst; it does not stall the link.
- Grants start only on slot boundaries.
- A reset mid-burst returns all state and outputs to their reset values in the next cycle. The FIFO is not popped in the reset cycle.

Decomposition:
- Shared package phy_pkg holds:
  - COMMA and SOC_BASE constants;
  - the state enum TRAIN/IDLE/BURST;
  - the width constants CNT_W=4 and CH_W=2.
- One sub-module, rr_pick: a combinational round-robin priority picker (req vector plus start pointer gives a one-hot grant, an index, and an any flag). It is reused by the PHY RX-side scheduler.

Test Plan:
- Training: reset, then enable=1, ser_ready every 8 cycles, no requests -> 4 COMMA slots with active=0, then active=1; ser_data stays 8'hBC with ser_valid=0.
- Single burst split: channel 1 holds 6 bytes 01..06, others empty -> F1,01,02,03,04,F1,05,06,BC. req_pop[1] pulses 6 times, once per payload slot.
- Round-robin: all 4 channels hold 8 bytes -> SOC order F0,F1,F2,F3,F0 with 4 data bytes each; grant_ch follows 0,1,2,3,0.
- Mid-burst empty plus back-to-back: channel 0 has 2 bytes, channel 2 has 1 byte -> F0,a,b,F2,c,BC; no COMMA between b and F2.
- Enable drop: deassert enable during a channel 3 burst after 2 bytes -> next slot BC, active=0; 4 BC slots after re-enable, then F3 with the remaining bytes.
- Reserved byte and reset: channel 0 payload 8'hBC -> sent, err_reserved=1. Reset asserted mid-burst -> err_reserved=0, ser_data=BC, state TRAIN on the next cycle.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared constants, widths and FSM encoding for the PHY TX/RX lane schedulers.
package phy_pkg;

  localparam int CNT_W = 4;
  localparam int CH_W  = 2;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam logic [7:0] SOC_BASE = 8'hF0;

  localparam logic [1:0] ST_TRAIN = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  typedef enum logic [1:0] {
    TRAIN = ST_TRAIN,
    IDLE  = ST_IDLE,
    BURST = ST_BURST
  } state_e;

  // Payload bytes that collide with link control symbols.
  function automatic logic is_reserved(input logic [7:0] b, input int n_ch,
                                       input logic [7:0] comma, input logic [7:0] soc_base);
    int v;
    int base;
    v    = int'(b);
    base = int'(soc_base);
    return (b == comma) || ((v >= base) && (v < base + n_ch));
  endfunction

endpackage

// File: rtl/phy_tx_lane_scheduler_if.sv
// FIFO-side request/pop signals and serializer-side byte slot of the TX lane scheduler.
interface phy_tx_lane_scheduler_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0]   req_valid;
  logic [8*N_CH-1:0] req_data;
  logic [N_CH-1:0]   req_pop;
  logic              ser_ready;
  logic [7:0]        ser_data;
  logic              ser_valid;

  modport master (
    input  req_valid, req_data, ser_ready,
    output req_pop, ser_data, ser_valid
  );

  modport slave (
    output req_valid, req_data, ser_ready,
    input  req_pop, ser_data, ser_valid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i, with wrap.
module rr_pick
  import phy_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [CH_W-1:0] start_i,
  output logic [N-1:0]    gnt_o,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  logic [CH_W-1:0] pos [N];

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N) s = s - N;
    return CH_W'(s);
  endfunction

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pos
      assign pos[gi]   = wrap_add(start_i, gi);
      assign gnt_o[gi] = any_o && (idx_o == CH_W'(gi));
    end
  endgenerate

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[pos[i]]) begin
        idx_o = pos[i];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phy_tx_lane_scheduler.sv
// Shares one PHY TX byte slot among N_CH FIFOs: comma training, then round-robin SOC-framed bursts.
module phy_tx_lane_scheduler
  import phy_pkg::*;
#(
  parameter int         N_CH         = 4,
  parameter int         BURST_LEN    = 4,
  parameter int         TRAIN_LEN    = 4,
  parameter logic [7:0] COMMA_SYM    = COMMA,
  parameter logic [7:0] SOC_SYM_BASE = SOC_BASE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_i,
  phy_tx_lane_scheduler_if.master  lane_if,
  output logic                     active_o,
  output logic [CH_W-1:0]          grant_ch_o,
  output logic                     err_reserved_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  train_cnt_q, train_cnt_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
  logic [N_CH-1:0]   grant_oh_q, grant_oh_d;
  logic [7:0]        ser_data_q, ser_data_d;
  logic              ser_valid_q, ser_valid_d;
  logic              active_q, active_d;
  logic              err_q, err_d;

  logic [7:0]        lane_data   [N_CH];
  logic [7:0]        lane_masked [N_CH];
  logic [7:0]        head_byte;
  logic              head_valid;
  logic              burst_more;
  logic [CH_W-1:0]   next_ch;
  logic [CH_W-1:0]   pick_start;
  logic [CH_W-1:0]   pick_idx;
  logic [N_CH-1:0]   pick_gnt;
  logic              pick_any;
  logic              do_arb;
  logic [N_CH-1:0]   pop;
  logic [CNT_W-1:0]  train_inc;

  // Head byte of the granted lane via a one-hot AND-OR mux.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      assign lane_data[gi]   = lane_if.req_data[8*gi +: 8];
      assign lane_masked[gi] = lane_data[gi] & {8{grant_oh_q[gi]}};
    end
  endgenerate

  always_comb begin
    head_byte = '0;
    for (int i = 0; i < N_CH; i++) begin
      head_byte = head_byte | lane_masked[i];
    end
  end

  assign head_valid = |(lane_if.req_valid & grant_oh_q);
  assign burst_more = head_valid && (burst_cnt_q < CNT_W'(BURST_LEN));
  assign next_ch    = (grant_ch_q == CH_W'(N_CH - 1)) ? '0 : grant_ch_q + 1'b1;
  // A burst that ends re-arbitrates in the same slot starting past its own channel.
  assign pick_start = (state_q == BURST) ? next_ch : rr_ptr_q;
  assign train_inc  = train_cnt_q + 1'b1;

  rr_pick #(
    .N (N_CH)
  ) u_rr_pick (
    .req_i   (lane_if.req_valid),
    .start_i (pick_start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_ch_d  = grant_ch_q;
    grant_oh_d  = grant_oh_q;
    ser_data_d  = ser_data_q;
    ser_valid_d = ser_valid_q;
    active_d    = active_q;
    err_d       = err_q;
    pop         = '0;
    do_arb      = 1'b0;

    if (lane_if.ser_ready && !reset) begin
      case (state_q)
        TRAIN: begin
          ser_data_d  = COMMA_SYM;
          ser_valid_d = 1'b0;
          if (enable_i) begin
            train_cnt_d = train_inc;
            if (train_inc == CNT_W'(TRAIN_LEN)) begin
              state_d  = IDLE;
              active_d = 1'b1;
            end
          end else begin
            train_cnt_d = '0;
          end
        end
        IDLE, BURST: begin
          if (!enable_i) begin
            ser_data_d  = COMMA_SYM;
            ser_valid_d = 1'b0;
            state_d     = TRAIN;
            train_cnt_d = '0;
            active_d    = 1'b0;
          end else if (state_q == BURST && burst_more) begin
            ser_data_d  = head_byte;
            ser_valid_d = 1'b1;
            pop         = grant_oh_q;
            burst_cnt_d = burst_cnt_q + 1'b1;
            if (is_reserved(head_byte, N_CH, COMMA_SYM, SOC_SYM_BASE)) err_d = 1'b1;
          end else begin
            if (state_q == BURST) rr_ptr_d = next_ch;
            do_arb = 1'b1;
          end
        end
        default: begin
          state_d = TRAIN;
        end
      endcase

      if (do_arb) begin
        if (pick_any) begin
          ser_data_d  = SOC_SYM_BASE + {{(8 - CH_W){1'b0}}, pick_idx};
          ser_valid_d = 1'b1;
          grant_ch_d  = pick_idx;
          grant_oh_d  = pick_gnt;
          burst_cnt_d = '0;
          state_d     = BURST;
        end else begin
          ser_data_d  = COMMA_SYM;
          ser_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    end else if (state_q == TRAIN && !enable_i) begin
      train_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TRAIN;
      train_cnt_q <= '0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
      grant_ch_q  <= '0;
      grant_oh_q  <= N_CH'(1);
      ser_data_q  <= COMMA_SYM;
      ser_valid_q <= 1'b0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_ch_q  <= grant_ch_d;
      grant_oh_q  <= grant_oh_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      active_q    <= active_d;
      err_q       <= err_d;
    end
  end

  assign lane_if.req_pop   = pop;
  assign lane_if.ser_data  = ser_data_q;
  assign lane_if.ser_valid = ser_valid_q;
  assign active_o          = active_q;
  assign grant_ch_o        = grant_ch_q;
  assign err_reserved_o    = err_q;

endmodule
